// File: rtl/lsu_pkg.sv
// Shared types and defaults for the load/store unit.
// Holds the FSM state encoding and the default data/address widths.
package lsu_pkg;

    localparam int unsigned LSU_W = 8;
    localparam int unsigned LSU_A = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2,
        RESP = 2'd3
    } lsu_state_e;

endpackage

// File: rtl/load_store_unit.sv
// Load/store unit: one- or two-byte accesses to a byte-wide data memory.
// Ports: Clk/Reset (sync, active-high); Req* request handshake in;
// Rsp* one-cycle completion out; Mem* drive an external memory whose
// read data MemRData is combinational from MemAddr.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int W = LSU_W,
    parameter int A = LSU_A
) (
    input  logic           Clk,
    input  logic           Reset,
    input  logic           ReqValid,
    output logic           ReqReady,
    input  logic           ReqWrite,
    input  logic           ReqWide,
    input  logic [A-1:0]   ReqAddr,
    input  logic [2*W-1:0] ReqWData,
    output logic           RspValid,
    output logic [2*W-1:0] RspRData,
    output logic [A-1:0]   MemAddr,
    output logic           MemWriteEn,
    output logic [W-1:0]   MemWData,
    input  logic [W-1:0]   MemRData
);

    lsu_state_e     state_q, state_d;
    logic           write_q, write_d;
    logic           wide_q,  wide_d;
    logic [A-1:0]   addr_q,  addr_d;
    logic [2*W-1:0] wdata_q, wdata_d;
    logic [2*W-1:0] rdata_q, rdata_d;

    always_comb begin
        state_d = state_q;
        write_d = write_q;
        wide_d  = wide_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (ReqValid) begin
                    write_d = ReqWrite;
                    wide_d  = ReqWide;
                    addr_d  = ReqAddr;
                    wdata_d = ReqWData;
                    // stores report zero, byte loads zero-extend
                    rdata_d = '0;
                    state_d = ACC0;
                end
            end
            ACC0: begin
                if (!write_q) begin
                    rdata_d[W-1:0] = MemRData;
                end
                state_d = wide_q ? ACC1 : RESP;
            end
            ACC1: begin
                if (!write_q) begin
                    rdata_d[2*W-1:W] = MemRData;
                end
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            write_q <= 1'b0;
            wide_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            wide_q  <= wide_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Memory outputs are decoded from the current state only, so a
    // write already on the bus still commits if Reset hits mid-access.
    always_comb begin
        MemAddr    = '0;
        MemWData   = '0;
        MemWriteEn = 1'b0;
        unique case (state_q)
            ACC0: begin
                MemAddr    = addr_q;
                MemWData   = wdata_q[W-1:0];
                MemWriteEn = write_q;
            end
            ACC1: begin
                // natural A-bit wrap from the top address to zero
                MemAddr    = addr_q + A'(1);
                MemWData   = wdata_q[2*W-1:W];
                MemWriteEn = write_q;
            end
            default: begin
                MemAddr    = '0;
                MemWData   = '0;
                MemWriteEn = 1'b0;
            end
        endcase
    end

    assign ReqReady = (state_q == IDLE);
    assign RspValid = (state_q == RESP);
    assign RspRData = RspValid ? rdata_q : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit.
// Bench owns the data memory and a cycle-level behavioural reference.
module tb_load_store_unit;
    import lsu_pkg::*;

    localparam int W = 8;
    localparam int A = 8;

    logic           Clk = 1'b0;
    logic           Reset;
    logic           ReqValid;
    logic           ReqReady;
    logic           ReqWrite;
    logic           ReqWide;
    logic [A-1:0]   ReqAddr;
    logic [2*W-1:0] ReqWData;
    logic           RspValid;
    logic [2*W-1:0] RspRData;
    logic [A-1:0]   MemAddr;
    logic           MemWriteEn;
    logic [W-1:0]   MemWData;
    logic [W-1:0]   MemRData;

    load_store_unit #(.W(W), .A(A)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .ReqValid   (ReqValid),
        .ReqReady   (ReqReady),
        .ReqWrite   (ReqWrite),
        .ReqWide    (ReqWide),
        .ReqAddr    (ReqAddr),
        .ReqWData   (ReqWData),
        .RspValid   (RspValid),
        .RspRData   (RspRData),
        .MemAddr    (MemAddr),
        .MemWriteEn (MemWriteEn),
        .MemWData   (MemWData),
        .MemRData   (MemRData)
    );

    always #5 Clk = ~Clk;

    logic [7:0] mem [0:255];
    assign MemRData = mem[MemAddr];
    always @(posedge Clk) begin
        if (MemWriteEn) mem[MemAddr] <= MemWData;
    end

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Reference model: byte writes scheduled for the cycle they commit,
    // responses scheduled for the cycle they must appear.
    typedef struct {
        int         c;
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;
    typedef struct {
        int          c;
        logic [15:0] d;
    } rsp_t;

    wr_t        pend[$];
    rsp_t       rq[$];
    logic [7:0] ref_mem [0:255];
    int         next_free = 0;
    bit         started = 0;
    int         rsp_count = 0;
    logic [15:0] last_rsp = '0;

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 8'(i) ^ 8'h5C;
            ref_mem[i] = 8'(i) ^ 8'h5C;
        end
    end

    always @(negedge Clk) begin : model_p
        int          n;
        bit          wr_exp;
        logic [7:0]  ea;
        logic [7:0]  ed;
        logic [7:0]  a1;
        logic [15:0] data;
        n = cyc;
        if (started) begin
            chk("ready", {31'd0, ReqReady}, {31'd0, n >= next_free});
            wr_exp = 1'b0;
            ea = '0;
            ed = '0;
            foreach (pend[i]) begin
                if (pend[i].c == n) begin
                    wr_exp = 1'b1;
                    ea = pend[i].a;
                    ed = pend[i].d;
                end
            end
            chk("mem_wen", {31'd0, MemWriteEn}, {31'd0, wr_exp});
            if (wr_exp) begin
                chk("mem_addr", {24'd0, MemAddr}, {24'd0, ea});
                chk("mem_wdata", {24'd0, MemWData}, {24'd0, ed});
            end
            if (rq.size() > 0 && rq[0].c == n) begin
                chk("rsp_valid", {31'd0, RspValid}, 32'd1);
                chk("rsp_data", {16'd0, RspRData}, {16'd0, rq[0].d});
                void'(rq.pop_front());
            end else begin
                chk("rsp_valid", {31'd0, RspValid}, 32'd0);
            end
            if (RspValid) begin
                rsp_count++;
                last_rsp = RspRData;
            end
        end
        for (int i = pend.size() - 1; i >= 0; i--) begin
            if (pend[i].c == n) begin
                ref_mem[pend[i].a] = pend[i].d;
                pend.delete(i);
            end
        end
        if (Reset) begin
            for (int i = pend.size() - 1; i >= 0; i--) begin
                if (pend[i].c > n) pend.delete(i);
            end
            rq.delete();
            next_free = n + 1;
            started = 1'b1;
        end else if (started && ReqValid && n >= next_free) begin
            a1 = ReqAddr + 8'd1;
            if (ReqWrite) begin
                pend.push_back('{n + 1, ReqAddr, ReqWData[7:0]});
                if (ReqWide) pend.push_back('{n + 2, a1, ReqWData[15:8]});
                data = '0;
            end else begin
                data = {ReqWide ? ref_mem[a1] : 8'h00, ref_mem[ReqAddr]};
            end
            rq.push_back('{n + (ReqWide ? 3 : 2), data});
            next_free = n + (ReqWide ? 4 : 3);
        end
    end

    task automatic do_req(input bit w, input bit wd, input logic [7:0] a,
                          input logic [15:0] d,
                          output logic [15:0] rd, output int lat);
        int k;
        k = 0;
        while (!ReqReady && k < 10) begin
            @(posedge Clk);
            #1;
            k++;
        end
        if (!ReqReady) chk("ready_wait", {31'd0, ReqReady}, 32'd1);
        ReqValid = 1'b1;
        ReqWrite = w;
        ReqWide  = wd;
        ReqAddr  = a;
        ReqWData = d;
        @(posedge Clk);
        #1;
        // scramble inputs while busy; they must be ignored
        ReqValid = 1'b0;
        ReqWrite = ~w;
        ReqAddr  = ~a;
        ReqWData = ~d;
        lat = 0;
        rd  = '0;
        for (int j = 1; j <= 8; j++) begin
            @(negedge Clk);
            if (RspValid) begin
                lat = j;
                rd  = RspRData;
                break;
            end
        end
        if (lat == 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_timeout: got none want RspValid a=%0h", a);
        end
    endtask

    logic [15:0] rd;
    int          lat;
    int          rsp0;
    int          bad;

    initial begin
        Reset    = 1'b1;
        ReqValid = 1'b0;
        ReqWrite = 1'b0;
        ReqWide  = 1'b0;
        ReqAddr  = '0;
        ReqWData = '0;
        repeat (3) @(posedge Clk);
        #1;
        Reset = 1'b0;
        chk("reset_ready", {31'd0, ReqReady}, 32'd1);
        chk("reset_rspvalid", {31'd0, RspValid}, 32'd0);
        chk("reset_rdata", {16'd0, RspRData}, 32'd0);
        chk("reset_wen", {31'd0, MemWriteEn}, 32'd0);

        do_req(1'b1, 1'b0, 8'h10, 16'h005A, rd, lat);
        chk("bst_rdata", {16'd0, rd}, 32'h0000);
        chk("bst_lat", lat, 2);
        do_req(1'b0, 1'b0, 8'h10, 16'h0000, rd, lat);
        chk("bld_rdata", {16'd0, rd}, 32'h005A);
        chk("bld_lat", lat, 2);

        do_req(1'b1, 1'b1, 8'h20, 16'hBEEF, rd, lat);
        chk("wst_lat", lat, 3);
        chk("wst_mem20", {24'd0, mem[8'h20]}, 32'hEF);
        chk("wst_mem21", {24'd0, mem[8'h21]}, 32'hBE);
        do_req(1'b0, 1'b1, 8'h20, 16'h0000, rd, lat);
        chk("wld_rdata", {16'd0, rd}, 32'hBEEF);
        chk("wld_lat", lat, 3);

        do_req(1'b1, 1'b1, 8'hFF, 16'h1234, rd, lat);
        chk("wrap_memff", {24'd0, mem[8'hFF]}, 32'h34);
        chk("wrap_mem00", {24'd0, mem[8'h00]}, 32'h12);
        do_req(1'b0, 1'b1, 8'hFF, 16'h0000, rd, lat);
        chk("wrap_ld", {16'd0, rd}, 32'h1234);

        do_req(1'b0, 1'b0, 8'h21, 16'h0000, rd, lat);
        chk("bld_zext", {16'd0, rd}, 32'h00BE);

        // Reset during ACC0 of a wide store, then Reset vs handshake
        @(posedge Clk);
        #1;
        rsp0 = rsp_count;
        ReqValid = 1'b1;
        ReqWrite = 1'b1;
        ReqWide  = 1'b1;
        ReqAddr  = 8'h30;
        ReqWData = 16'hAAAA;
        @(posedge Clk);
        #1;
        ReqValid = 1'b0;
        Reset    = 1'b1;
        @(posedge Clk);
        #1;
        chk("rst_ready_during", {31'd0, ReqReady}, 32'd1);
        ReqValid = 1'b1;
        ReqWrite = 1'b1;
        ReqWide  = 1'b0;
        ReqAddr  = 8'h50;
        ReqWData = 16'h0099;
        @(posedge Clk);
        #1;
        Reset    = 1'b0;
        ReqValid = 1'b0;
        chk("rst_ready_after", {31'd0, ReqReady}, 32'd1);
        repeat (4) @(posedge Clk);
        #1;
        chk("rst_mem30", {24'd0, mem[8'h30]}, 32'hAA);
        chk("rst_mem31", {24'd0, mem[8'h31]}, 32'h6D);
        chk("rst_mem50", {24'd0, mem[8'h50]}, 32'h0C);
        chk("rst_no_rsp", rsp_count - rsp0, 0);

        // ReqValid held high with a moving address
        rsp0 = rsp_count;
        ReqValid = 1'b1;
        ReqWrite = 1'b0;
        ReqWide  = 1'b0;
        for (int i = 0; i < 12; i++) begin
            ReqAddr = 8'h40 + 8'(i);
            @(posedge Clk);
            #1;
        end
        ReqValid = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        chk("stream_count", rsp_count - rsp0, 4);
        chk("stream_last", {16'd0, last_rsp}, 32'h0015);

        bad = 0;
        for (int i = 0; i < 256; i++) begin
            if (mem[i] !== ref_mem[i]) bad++;
        end
        chk("mem_image", bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter W, default 8: memory data width in bits, one byte per memory entry.
REQ-002 SHALL have parameter A, default 8: memory address width, giving a 2**A-entry address space.
REQ-003 SHALL have port Clk  input  1  clock; all state updates on posedge Clk.
REQ-004 SHALL have port Reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port ReqValid  input  1  request present.
REQ-006 SHALL have port ReqReady  output  1  unit can accept a request this cycle.
REQ-007 SHALL have port ReqWrite  input  1  1=store, 0=load.
REQ-008 SHALL have port ReqWide  input  1  1=two-byte access, 0=one-byte access.
REQ-009 SHALL have port ReqAddr  input  A  base byte address.
REQ-010 SHALL have port ReqWData  input  2W  store data; low byte at the base address.
REQ-011 SHALL have port RspValid  output  1  one-cycle completion pulse.
REQ-012 SHALL have port RspRData  output  2W  load result, valid while RspValid=1.
REQ-013 SHALL have port MemAddr  output  A  data-memory address pointer.
REQ-014 SHALL have port MemWriteEn  output  1  data-memory write enable.
REQ-015 SHALL have port MemWData  output  W  data-memory write data.
REQ-016 SHALL have port MemRData  input  W  data-memory read data, combinational from MemAddr.

Function
REQ-017 SHALL implement the FSM IDLE, ACC0, ACC1, RESP.
REQ-018 SHALL drive ReqReady=1 only in IDLE.
REQ-019 SHALL, on a handshake (ReqValid and ReqReady at posedge), latch ReqWrite, ReqWide, ReqAddr and ReqWData, then enter ACC0.
REQ-020 SHALL ignore request inputs outside IDLE; changes while busy have no effect.
REQ-021 SHALL, in ACC0, drive MemAddr=latched address, MemWData=data[W-1:0] and MemWriteEn=latched write.
REQ-022 SHALL, at the posedge ending ACC0, capture MemRData into the result low byte on loads, then go to ACC1 if wide, else RESP.
REQ-023 SHALL, in ACC1, drive MemAddr=(address+1) mod 2**A, wrapping 0xFF->0x00 at A=8, with MemWData=data[2W-1:W] and MemWriteEn=latched write.
REQ-024 SHALL, at the posedge ending ACC1, capture MemRData into the result high byte on loads, then go to RESP.
REQ-025 SHALL, in RESP, assert RspValid for exactly one cycle, then go to IDLE.
REQ-026 SHALL set RspRData as follows: byte load = {zero, low byte}; wide load = {high, low}; store = 0.
REQ-027 SHALL have latency, counted from the handshake cycle: RspValid in cycle +2 for byte ops and cycle +3 for wide ops.
REQ-028 SHALL have throughput of one request per 3 cycles (byte) or 4 cycles (wide); the next accept comes in the IDLE cycle after RESP.
REQ-029 SHALL drive MemWriteEn=0, MemAddr=0 and MemWData=0 in IDLE and RESP.
REQ-030 SHALL treat a later request to a just-written address as reading the new value, since the memory write commits at the posedge ending the ACC cycle.

Reset
REQ-031 SHALL, on Reset at posedge, from any state: go to IDLE, clear the latched request and result, RspValid=0, RspRData=0, MemWriteEn=0, MemAddr=0, MemWData=0.
REQ-032 SHALL give Reset priority over a handshake in the same cycle; no request is accepted.
REQ-033 SHALL, on Reset asserted during ACC0 or ACC1, still commit that cycle's memory write, since the memory is independent; no further byte is written and no response is issued.
REQ-034 SHALL NOT modify memory contents through Reset.

Structure
REQ-035 SHALL place the FSM state enum (IDLE, ACC0, ACC1, RESP) and the W/A defaults in shared package lsu_pkg.
REQ-036 SHALL be a single module with no sub-module; the data memory instance lives in the parent datapath.

Verification
REQ-037 SHALL cover: byte store 0x5A at 0x10, then byte load 0x10 -> RspRData=0x005A, RspValid in cycle +2.
REQ-038 SHALL cover: wide store 0xBEEF at 0x20 -> mem[0x20]=0xEF, mem[0x21]=0xBE; wide load 0x20 -> RspRData=0xBEEF, RspValid in cycle +3.
REQ-039 SHALL cover: wide store 0x1234 at 0xFF -> mem[0xFF]=0x34, mem[0x00]=0x12 (wrap); wide load 0xFF -> 0x1234.
REQ-040 SHALL cover: Reset in ACC0 of wide store 0xAAAA at 0x30 -> mem[0x30]=0xAA, mem[0x31] unchanged, no RspValid, ReqReady=1 the next cycle.
REQ-041 SHALL cover: ReqValid held high with ReqAddr changing every cycle -> accept only when ReqReady=1, one RspValid per accepted request, data from the latched address only.
